window_scan_ctrl: RTL and testbench
===================================

Name: window_scan_ctrl

Overview:
- Sequencer for the convolution datapath. Generates the read-address stream for every KSIZE x KSIZE stride-1 window of a feature map held in on-chip memory.
- Sits directly upstream of the MAC/window buffer, feeding it one pixel address per handshake.
- Exposes window/frame boundary flags so the downstream stage can load and clear its accumulation counters.
- Single rising-edge clock domain.

Parameters:
- ADDR_W, 16, width of memory address and base address.
- DIM_W, 10, width of image width/height and row/column indices.
- KSIZE, 3, kernel side length; legal values 1..7.

Ports:
- WSCAN_Clk  input  1  clock; all state updates on rising edge.
- WSCAN_Clr  input  1  reset, synchronous, active-high.
- WSCAN_Start  input  1  one-cycle pulse; begins a frame scan when idle.
- WSCAN_Width  input  DIM_W  image width in pixels; sampled on accepted Start.
- WSCAN_Height  input  DIM_W  image height in pixels; sampled on accepted Start.
- WSCAN_Base  input  ADDR_W  address of pixel (0,0); sampled on accepted Start.
- WSCAN_Ready  input  1  downstream can accept the current address.
- WSCAN_Addr  output  ADDR_W  pixel read address.
- WSCAN_Valid  output  1  WSCAN_Addr is valid.
- WSCAN_WinFirst  output  1  current beat is the first pixel of a window (kr=0, kc=0).
- WSCAN_WinLast  output  1  current beat is the last pixel of a window (kr=kc=KSIZE-1).
- WSCAN_FrameLast  output  1  current beat is the last beat of the frame.
- WSCAN_OutRow  output  DIM_W  output-map row of the current window.
- WSCAN_OutCol  output  DIM_W  output-map column of the current window.
- WSCAN_Busy  output  1  scan in progress (state SCAN).
- WSCAN_Done  output  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (Clr=1 at a rising edge): state IDLE. All outputs 0, all internal counters 0. Reset mid-scan aborts the scan immediately; no Done pulse is generated.
- FSM has three states: IDLE, SCAN, DONE.
  - IDLE:
    - Start=1 latches Width, Height and Base.
    - If Width<KSIZE or Height<KSIZE, go to DONE with zero beats issued.
    - Otherwise go to SCAN with OutRow=OutCol=kr=kc=0.
  - SCAN: Valid=1. On a handshake (Valid and Ready in the same cycle), advance kc, then kr, then OutCol, then OutRow, in that order. The handshake on the FrameLast beat goes to DONE.
  - DONE: Done=1 for exactly one cycle, Busy=0, then IDLE.
- Start while in SCAN or DONE is ignored. Config inputs are ignored except on an accepted Start.
- Latency:
  - Start accepted at edge n: Valid=1 and first address present from edge n onward.
  - Last handshake at edge m: Valid=0 and Done=1 after edge m; IDLE after edge m+1.
- Handshake:
  - While Valid=1 and Ready=0, Addr and all flags hold stable.
  - Valid never drops mid-frame.
  - Zero-bubble: one beat per cycle when Ready is held at 1.
- Address: Addr = Base + (OutRow+kr)*Width + (OutCol+kc), truncated modulo 2^ADDR_W (wrap-around is silent).
  - Addr is computed incrementally with a row-base register and adders. No multiplier is allowed.
- Ranges: OutCol runs 0..Width-KSIZE; OutRow runs 0..Height-KSIZE.
- Beats per frame: (Width-KSIZE+1)*(Height-KSIZE+1)*KSIZE*KSIZE.
- Flags are combinational decodes of the registered indices and are valid only while Valid=1. They are 0 otherwise.
- KSIZE=1: WinFirst and WinLast are both 1 on every beat.
- FrameLast implies WinLast.
- Width=KSIZE and Height=KSIZE: exactly one window.

Test Plan:
- Base=0x100, W=4, H=4, KSIZE=3, Ready=1 -> 36 consecutive beats.
  - Window 0 addrs: 100, 101, 102, 104, 105, 106, 108, 109, 10A.
  - Window 1 starts at 101; window 2 (OutRow=1, OutCol=0) starts at 104.
  - Last beat addr 10F with FrameLast=1.
  - Done one cycle later.
- Same config, Ready toggled pseudo-randomly -> identical 36-address sequence; Addr and flags stable whenever Ready=0.
- W=2, H=5 (Width<KSIZE) -> no Valid beats; Done pulses one cycle after Start; back to IDLE.
- Start pulsed again mid-scan with W=8 -> ignored; original 36-beat frame completes unchanged.
- Clr asserted at beat 10 -> next cycle Valid=0, Busy=0, no Done. A new Start then restarts from the first address.
- Base=0xFFFE, W=3, H=3 -> addresses FFFE, FFFF, 0000, 0001, …, ending at 0006; single window with WinFirst on beat 0 and WinLast=FrameLast on beat 8.

Source files
------------

// File: rtl/window_scan_ctrl.sv
// Window scan sequencer: walks every KSIZE x KSIZE stride-1 window of a feature map and
// emits one pixel read address per handshake, with window/frame boundary flags.
module window_scan_ctrl #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DIM_W  = 10,
  parameter int unsigned KSIZE  = 3
) (
  input  logic              WSCAN_Clk,
  input  logic              WSCAN_Clr,
  input  logic              WSCAN_Start,
  input  logic [DIM_W-1:0]  WSCAN_Width,
  input  logic [DIM_W-1:0]  WSCAN_Height,
  input  logic [ADDR_W-1:0] WSCAN_Base,
  input  logic              WSCAN_Ready,
  output logic [ADDR_W-1:0] WSCAN_Addr,
  output logic              WSCAN_Valid,
  output logic              WSCAN_WinFirst,
  output logic              WSCAN_WinLast,
  output logic              WSCAN_FrameLast,
  output logic [DIM_W-1:0]  WSCAN_OutRow,
  output logic [DIM_W-1:0]  WSCAN_OutCol,
  output logic              WSCAN_Busy,
  output logic              WSCAN_Done
);

  localparam int unsigned KW = (KSIZE > 1) ? $clog2(KSIZE) : 1;
  localparam logic [KW-1:0]     KMax  = KW'(KSIZE - 1);
  localparam logic [DIM_W-1:0]  KDim  = DIM_W'(KSIZE);
  localparam logic [ADDR_W-1:0] KStep = ADDR_W'(KSIZE - 1);

  typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

  state_e            state_q;
  logic [DIM_W-1:0]  width_q, height_q;
  logic [DIM_W-1:0]  out_row_q, out_col_q;
  logic [KW-1:0]     kr_q, kc_q;
  // row_base = Base + OutRow*Width, win_base = row_base + OutCol, addr = current pixel
  logic [ADDR_W-1:0] row_base_q, win_base_q, addr_q;

  logic [ADDR_W-1:0] width_a;
  logic              scan;
  logic              kc_last, kr_last, col_last, row_last;

  assign width_a  = ADDR_W'(width_q);
  assign scan     = (state_q == StScan);
  assign kc_last  = (kc_q == KMax);
  assign kr_last  = (kr_q == KMax);
  assign col_last = (out_col_q == width_q - KDim);
  assign row_last = (out_row_q == height_q - KDim);

  always_ff @(posedge WSCAN_Clk) begin
    if (WSCAN_Clr) begin
      state_q    <= StIdle;
      width_q    <= '0;
      height_q   <= '0;
      out_row_q  <= '0;
      out_col_q  <= '0;
      kr_q       <= '0;
      kc_q       <= '0;
      row_base_q <= '0;
      win_base_q <= '0;
      addr_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (WSCAN_Start) begin
            width_q    <= WSCAN_Width;
            height_q   <= WSCAN_Height;
            out_row_q  <= '0;
            out_col_q  <= '0;
            kr_q       <= '0;
            kc_q       <= '0;
            row_base_q <= WSCAN_Base;
            win_base_q <= WSCAN_Base;
            addr_q     <= WSCAN_Base;
            if ((WSCAN_Width < KDim) || (WSCAN_Height < KDim)) begin
              state_q <= StDone;
            end else begin
              state_q <= StScan;
            end
          end
        end
        StScan: begin
          if (WSCAN_Ready) begin
            if (!kc_last) begin
              kc_q   <= kc_q + KW'(1);
              addr_q <= addr_q + ADDR_W'(1);
            end else if (!kr_last) begin
              // Step down one image row and back to the window's left column
              kc_q   <= '0;
              kr_q   <= kr_q + KW'(1);
              addr_q <= addr_q + width_a - KStep;
            end else if (!col_last) begin
              kc_q       <= '0;
              kr_q       <= '0;
              out_col_q  <= out_col_q + DIM_W'(1);
              win_base_q <= win_base_q + ADDR_W'(1);
              addr_q     <= win_base_q + ADDR_W'(1);
            end else if (!row_last) begin
              kc_q       <= '0;
              kr_q       <= '0;
              out_col_q  <= '0;
              out_row_q  <= out_row_q + DIM_W'(1);
              row_base_q <= row_base_q + width_a;
              win_base_q <= row_base_q + width_a;
              addr_q     <= row_base_q + width_a;
            end else begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  always_comb begin
    WSCAN_Valid     = scan;
    WSCAN_Addr      = scan ? addr_q : '0;
    WSCAN_OutRow    = scan ? out_row_q : '0;
    WSCAN_OutCol    = scan ? out_col_q : '0;
    WSCAN_WinFirst  = scan && (kr_q == '0) && (kc_q == '0);
    WSCAN_WinLast   = scan && kr_last && kc_last;
    WSCAN_FrameLast = scan && kr_last && kc_last && col_last && row_last;
    WSCAN_Busy      = scan;
    WSCAN_Done      = (state_q == StDone);
  end

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Directed bench for window_scan_ctrl: full frames with steady and random Ready, short
// frames, ignored mid-scan Start, mid-scan Clr and address wrap-around.
module tb_window_scan_ctrl;

  localparam int AW = 16;
  localparam int DW = 10;
  localparam int K  = 3;

  logic          clk = 1'b0;
  logic          clr, start, ready;
  logic [DW-1:0] width, height;
  logic [AW-1:0] base;
  logic [AW-1:0] addr;
  logic          valid, winfirst, winlast, framelast, busy, done;
  logic [DW-1:0] outrow, outcol;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  window_scan_ctrl #(
    .ADDR_W(AW),
    .DIM_W (DW),
    .KSIZE (K)
  ) dut (
    .WSCAN_Clk      (clk),
    .WSCAN_Clr      (clr),
    .WSCAN_Start    (start),
    .WSCAN_Width    (width),
    .WSCAN_Height   (height),
    .WSCAN_Base     (base),
    .WSCAN_Ready    (ready),
    .WSCAN_Addr     (addr),
    .WSCAN_Valid    (valid),
    .WSCAN_WinFirst (winfirst),
    .WSCAN_WinLast  (winlast),
    .WSCAN_FrameLast(framelast),
    .WSCAN_OutRow   (outrow),
    .WSCAN_OutCol   (outcol),
    .WSCAN_Busy     (busy),
    .WSCAN_Done     (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input int w, r, c, kr, kc);
    return b + AW'((r + kr) * w + c + kc);
  endfunction

  task automatic do_start(input logic [AW-1:0] b, input int w, h);
    base   = b;
    width  = DW'(w);
    height = DH(h);
    start  = 1'b1;
    tick();
    start  = 1'b0;
    width  = '0;
    height = '0;
    base   = '0;
  endtask

  function automatic logic [DW-1:0] DH(input int h);
    return DW'(h);
  endfunction

  // Expects the scan to be running with beat 0 presented; consumes the whole frame.
  task automatic scan_frame(input logic [AW-1:0] b, input int w, h, input bit rnd, input bit poke);
    int beat = 0;
    for (int r = 0; r <= h - K; r++) begin
      for (int c = 0; c <= w - K; c++) begin
        for (int kr = 0; kr < K; kr++) begin
          for (int kc = 0; kc < K; kc++) begin
            int  waits = 0;
            bit  wl    = (kr == K - 1) && (kc == K - 1);
            bit  fl    = wl && (r == h - K) && (c == w - K);
            logic [AW-1:0] ea = exp_addr(b, w, r, c, kr, kc);
            ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            while (!ready && waits < 8) begin
              chk("hold_valid", valid, 1);
              chk("hold_addr", addr, ea);
              chk("hold_winlast", winlast, wl);
              chk("hold_framelast", framelast, fl);
              tick();
              waits++;
              ready = 1'($urandom_range(0, 1));
            end
            ready = 1'b1;
            chk("valid", valid, 1);
            chk("addr", addr, ea);
            chk("winfirst", winfirst, (kr == 0) && (kc == 0));
            chk("winlast", winlast, wl);
            chk("framelast", framelast, fl);
            chk("outrow", outrow, r);
            chk("outcol", outcol, c);
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            if (poke && beat == 5) begin
              start  = 1'b1;
              width  = DW'(8);
              height = DW'(8);
              base   = 16'h0;
            end
            tick();
            start = 1'b0;
            beat++;
          end
        end
      end
    end
    chk("end_valid", valid, 0);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_addr", addr, 0);
    tick();
    chk("idle_done", done, 0);
    chk("idle_valid", valid, 0);
  endtask

  initial begin
    clr    = 1'b1;
    start  = 1'b0;
    ready  = 1'b0;
    width  = '0;
    height = '0;
    base   = '0;
    tick();
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_winfirst", winfirst, 0);
    chk("rst_framelast", framelast, 0);
    clr = 1'b0;
    tick();
    chk("idle_valid0", valid, 0);

    // 4x4 frame, Ready held high
    do_start(16'h0100, 4, 4);
    chk("first_addr", addr, 16'h0100);
    scan_frame(16'h0100, 4, 4, 1'b0, 1'b0);

    // Same frame with random Ready
    do_start(16'h0100, 4, 4);
    scan_frame(16'h0100, 4, 4, 1'b1, 1'b0);

    // Width below kernel: immediate Done, no beats
    do_start(16'h0000, 2, 5);
    chk("short_valid", valid, 0);
    chk("short_done", done, 1);
    chk("short_busy", busy, 0);
    tick();
    chk("short_done_off", done, 0);
    chk("short_valid_off", valid, 0);

    // Start pulsed mid-scan must be ignored
    do_start(16'h0100, 4, 4);
    scan_frame(16'h0100, 4, 4, 1'b0, 1'b1);

    // Clr at beat 10 aborts without Done
    do_start(16'h0100, 4, 4);
    ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("pre_clr_addr", addr, 16'h0102);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid", valid, 0);
    chk("clr_busy", busy, 0);
    chk("clr_done", done, 0);
    tick();
    chk("clr_done_later", done, 0);
    do_start(16'h0100, 4, 4);
    chk("restart_addr", addr, 16'h0100);
    scan_frame(16'h0100, 4, 4, 1'b0, 1'b0);

    // Address wrap-around, single window
    do_start(16'hFFFE, 3, 3);
    chk("wrap_first", addr, 16'hFFFE);
    scan_frame(16'hFFFE, 3, 3, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
